// File: rtl/nn_pkg.sv
// Shared constants, FSM state type and the requantization function for nn_act_quant.
// Clamp mode is selected by macro NN_ACT_RELU_EN (defined: ReLU 0..127, undefined: -128..127).
package nn_pkg;

   localparam int unsigned ACC_W = 32;
   localparam int unsigned ACT_W = 8;

   typedef enum logic [1:0] {
      StIdle,
      StRun,
      StFlush
   } nn_state_e;

   // Add, round half-up, arithmetic shift, then clamp to an 8-bit activation.
   function automatic logic [ACT_W-1:0] requant(input logic [ACC_W-1:0] acc,
                                                input logic [ACC_W-1:0] bias,
                                                input int unsigned shift);
      logic signed [ACC_W+1:0] s;
      logic signed [ACC_W+1:0] r;
      logic signed [ACC_W+1:0] rnd;
      rnd = 34'sd1 <<< (shift - 1);
      // Two guard bits: the sum of two 32-bit operands plus the rounding term cannot overflow.
      s = $signed({{2{acc[ACC_W-1]}}, acc}) + $signed({{2{bias[ACC_W-1]}}, bias}) + rnd;
      r = s >>> shift;
`ifdef NN_ACT_RELU_EN
      if (r < 34'sd0) begin
         return 8'h00;
      end else if (r > 34'sd127) begin
         return 8'h7f;
      end
`else
      if (r < -34'sd128) begin
         return 8'h80;
      end else if (r > 34'sd127) begin
         return 8'h7f;
      end
`endif
      return r[ACT_W-1:0];
   endfunction

endpackage

// File: rtl/nn_requant.sv
// Combinational requantization of one accumulator/bias pair to one activation byte.
// Clamp mode follows macro NN_ACT_RELU_EN through nn_pkg::requant.
module nn_requant
   import nn_pkg::*;
#(
   parameter int unsigned SHIFT = 8
) (
   input  logic [ACC_W-1:0] acc,
   input  logic [ACC_W-1:0] bias,
   output logic [ACT_W-1:0] act
);

   always_comb begin
      act = requant(acc, bias, SHIFT);
   end

endmodule

// File: rtl/nn_act_quant.sv
// Requantizes a frame of N_NEURON accumulators and packs four activations per output word.
// Macro NN_ACT_RELU_EN selects ReLU clamping; otherwise signed saturation is used.
module nn_act_quant
   import nn_pkg::*;
#(
   parameter int unsigned N_NEURON = 50,
   parameter int unsigned SHIFT    = 8
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_valid,
   output logic             o_ready,
   input  logic [ACC_W-1:0] i_acc,
   input  logic [ACC_W-1:0] i_bias,
   output logic             o_valid,
   input  logic             i_ready,
   output logic [31:0]      o_data,
   output logic             o_last,
   output logic             o_busy
);

   localparam logic [7:0] LAST_IDX = 8'(N_NEURON - 1);

   nn_state_e        state;
   logic [7:0]       neuron;
   logic [1:0]       lane;
   logic [31:0]      pack;
   logic [31:0]      pack_next;
   logic [ACT_W-1:0] act;
   logic             in_fire;
   logic             out_fire;
   logic             last_neuron;
   logic             word_done;

   nn_requant #(
      .SHIFT (SHIFT)
   ) u_requant (
      .acc  (i_acc),
      .bias (i_bias),
      .act  (act)
   );

   // FLUSH blocks new pairs until the final word leaves, so frames never merge.
   assign o_ready     = (state != StFlush) && (!o_valid || i_ready);
   assign in_fire     = i_valid && o_ready;
   assign out_fire    = o_valid && i_ready;
   assign last_neuron = (neuron == LAST_IDX);
   assign word_done   = last_neuron || (lane == 2'd3);

   always_comb begin
      pack_next = pack;
      unique case (lane)
         2'd0: pack_next[31:24] = act;
         2'd1: pack_next[23:16] = act;
         2'd2: pack_next[15:8]  = act;
         2'd3: pack_next[7:0]   = act;
         default: pack_next = pack;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state   <= StIdle;
         neuron  <= '0;
         lane    <= '0;
         pack    <= '0;
         o_valid <= 1'b0;
         o_data  <= '0;
         o_last  <= 1'b0;
         o_busy  <= 1'b0;
      end else begin
         if (out_fire) begin
            o_valid <= 1'b0;
            o_last  <= 1'b0;
         end
         // A completing transfer may overwrite a word draining in the same cycle.
         if (in_fire) begin
            if (word_done) begin
               o_valid <= 1'b1;
               o_data  <= pack_next;
               o_last  <= last_neuron;
               pack    <= '0;
               lane    <= '0;
            end else begin
               pack <= pack_next;
               lane <= lane + 2'd1;
            end
            neuron <= last_neuron ? 8'd0 : neuron + 8'd1;
         end
         case (state)
            StIdle: begin
               if (in_fire) begin
                  state  <= last_neuron ? StFlush : StRun;
                  o_busy <= 1'b1;
               end
            end
            StRun: begin
               if (in_fire && last_neuron) begin
                  state <= StFlush;
               end
            end
            StFlush: begin
               if (out_fire) begin
                  state  <= StIdle;
                  o_busy <= 1'b0;
               end
            end
            default: begin
               state  <= StIdle;
               o_busy <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_nn_act_quant.sv
// Bench for nn_act_quant (N_NEURON=50, SHIFT=8): frame-level model plus literal word checks.
// Expectations follow macro NN_ACT_RELU_EN the same way the design does.
module tb_nn_act_quant;

   localparam int N     = 50;
   localparam int SHIFT = 8;

`ifdef NN_ACT_RELU_EN
   localparam logic [31:0] SIGN_WORD0 = 32'h007f0013;
`else
   localparam logic [31:0] SIGN_WORD0 = 32'hf07f8013;
`endif

   logic        i_clk = 1'b0;
   logic        i_rst_n = 1'b0;
   logic        i_valid = 1'b0;
   logic        o_ready;
   logic [31:0] i_acc = '0;
   logic [31:0] i_bias = '0;
   logic        o_valid;
   logic        i_ready = 1'b1;
   logic [31:0] o_data;
   logic        o_last;
   logic        o_busy;

   int total = 0;
   int bad = 0;

   typedef struct {
      logic [31:0] d;
      logic        l;
   } word_t;

   word_t       exp_q[$];
   int          m_n = 0;
   logic [31:0] m_pack = '0;
   bit          m_flush = 1'b0;

   logic [31:0] got_words[256];
   logic        got_last[256];
   int          got_n = 0;

   logic [31:0] acc_tab[N];
   logic [31:0] bias_tab[N];

   nn_act_quant #(
      .N_NEURON (N),
      .SHIFT    (SHIFT)
   ) dut (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_valid (i_valid),
      .o_ready (o_ready),
      .i_acc   (i_acc),
      .i_bias  (i_bias),
      .o_valid (o_valid),
      .i_ready (i_ready),
      .o_data  (o_data),
      .o_last  (o_last),
      .o_busy  (o_busy)
   );

   always #5 i_clk = ~i_clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // Plain integer arithmetic on 64 bits, then clamp.
   function automatic logic [7:0] model_act(input logic [31:0] a, input logic [31:0] b);
      longint s;
      longint r;
      s = longint'($signed(a)) + longint'($signed(b)) + (longint'(1) << (SHIFT - 1));
      r = s >>> SHIFT;
`ifdef NN_ACT_RELU_EN
      if (r < 0) r = 0;
      if (r > 127) r = 127;
`else
      if (r < -128) r = -128;
      if (r > 127) r = 127;
`endif
      return 8'(r);
   endfunction

   // Compare process: outputs are sampled on the falling edge, handshakes land on the next rise.
   initial begin
      word_t w;
      logic [7:0] b;
      forever begin
         @(negedge i_clk);
         if (!i_rst_n) begin
            exp_q.delete();
            m_n = 0;
            m_pack = '0;
            m_flush = 1'b0;
         end else begin
            chk("o_valid", 32'(o_valid), 32'(exp_q.size() != 0));
            chk("o_busy", 32'(o_busy), 32'(m_n != 0 || m_flush));
            chk("o_ready", 32'(o_ready), 32'(!m_flush && (!o_valid || i_ready)));
            if (o_valid && exp_q.size() != 0) begin
               w = exp_q[0];
               chk("o_data", o_data, w.d);
               chk("o_last", 32'(o_last), 32'(w.l));
               if (i_ready) begin
                  void'(exp_q.pop_front());
                  got_words[got_n[7:0]] = o_data;
                  got_last[got_n[7:0]] = o_last;
                  got_n++;
                  if (w.l) m_flush = 1'b0;
               end
            end
            if (i_valid && o_ready) begin
               b = model_act(i_acc, i_bias);
               m_pack = m_pack | ({24'b0, b} << (8 * (3 - (m_n % 4))));
               if ((m_n % 4) == 3 || m_n == N - 1) begin
                  w.d = m_pack;
                  w.l = (m_n == N - 1);
                  exp_q.push_back(w);
                  m_pack = '0;
               end
               if (m_n == N - 1) begin
                  m_n = 0;
                  m_flush = 1'b1;
               end else begin
                  m_n++;
               end
            end
         end
      end
   end

   task automatic send_pair(input logic [31:0] a, input logic [31:0] b);
      int tries;
      tries = 0;
      i_valid = 1'b1;
      i_acc = a;
      i_bias = b;
      forever begin
         @(negedge i_clk);
         if (o_ready) break;
         tries++;
         if (tries > 200) begin
            chk("send_timeout", 32'(tries), 32'd0);
            break;
         end
      end
      @(posedge i_clk);
      #1;
      i_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int cyc;
      cyc = 0;
      @(negedge i_clk);
      while (o_busy && cyc < 300) begin
         @(negedge i_clk);
         cyc++;
      end
      chk("idle_timeout", 32'(o_busy), 32'd0);
      @(posedge i_clk);
      #1;
   endtask

   task automatic run_frame(output int base);
      base = got_n;
      for (int i = 0; i < N; i++) send_pair(acc_tab[i], bias_tab[i]);
      wait_idle();
      chk("word_count", 32'(got_n - base), 32'd13);
      chk("last_on_13", 32'(got_last[(base + 12) % 256]), 32'd1);
      chk("no_last_on_12", 32'(got_last[(base + 11) % 256]), 32'd0);
   endtask

   task automatic fill_const();
      for (int i = 0; i < N; i++) begin
         acc_tab[i] = 32'h00001280;
         bias_tab[i] = '0;
      end
   endtask

   task automatic fill_ramp();
      for (int i = 0; i < N; i++) begin
         acc_tab[i] = 32'(i * 256);
         bias_tab[i] = '0;
      end
   endtask

   initial begin
      int base;
      int cyc;
      // Reset state
      #2;
      chk("rst_o_valid", 32'(o_valid), 32'd0);
      chk("rst_o_data", o_data, 32'd0);
      chk("rst_o_busy", 32'(o_busy), 32'd0);
      chk("rst_o_ready", 32'(o_ready), 32'd1);
      repeat (3) @(posedge i_clk);
      #1;
      i_rst_n = 1'b1;
      chk("post_rst_o_ready", 32'(o_ready), 32'd1);

      // Constant frame: 0x1280 -> 0x13 everywhere
      fill_const();
      run_frame(base);
      chk("const_w0", got_words[base % 256], 32'h13131313);
      chk("const_w11", got_words[(base + 11) % 256], 32'h13131313);
      chk("const_w12", got_words[(base + 12) % 256], 32'h13130000);
      chk("const_busy_end", 32'(o_busy), 32'd0);

      // Rounding around the half-LSB point
      fill_const();
      acc_tab[0] = 32'h0000007f;
      acc_tab[1] = 32'h00000080;
      acc_tab[2] = 32'h0000017f;
      acc_tab[3] = 32'h00000180;
      run_frame(base);
      chk("round_w0", got_words[base % 256], 32'h00010102);

      // Negative input and saturation without wrap
      fill_const();
      acc_tab[0] = 32'hfffff000;
      acc_tab[1] = 32'h7fffffff;
      bias_tab[1] = 32'h7fffffff;
      acc_tab[2] = 32'h80000000;
      bias_tab[2] = 32'h80000000;
      run_frame(base);
      chk("sign_w0", got_words[base % 256], SIGN_WORD0);

      // Backpressure: hold i_ready low for 10 cycles once the first word is out
      fill_ramp();
      base = got_n;
      fork
         begin
            for (int i = 0; i < N; i++) send_pair(acc_tab[i], bias_tab[i]);
         end
         begin
            i_ready = 1'b0;
            cyc = 0;
            @(negedge i_clk);
            while (!o_valid && cyc < 100) begin
               @(negedge i_clk);
               cyc++;
            end
            chk("bp_first_valid", 32'(o_valid), 32'd1);
            for (int k = 0; k < 10; k++) begin
               chk("bp_hold_valid", 32'(o_valid), 32'd1);
               chk("bp_hold_data", o_data, 32'h00010203);
               chk("bp_hold_ready", 32'(o_ready), 32'd0);
               @(negedge i_clk);
            end
            @(posedge i_clk);
            #1;
            i_ready = 1'b1;
         end
      join
      wait_idle();
      chk("bp_word_count", 32'(got_n - base), 32'd13);
      chk("bp_w0", got_words[base % 256], 32'h00010203);
      chk("bp_w1", got_words[(base + 1) % 256], 32'h04050607);
      chk("bp_w12", got_words[(base + 12) % 256], 32'h30310000);

      // Reset after 23 pairs discards the partial frame
      fill_ramp();
      for (int i = 0; i < 23; i++) send_pair(acc_tab[i], bias_tab[i]);
      #1;
      i_rst_n = 1'b0;
      #1;
      chk("mid_rst_o_valid", 32'(o_valid), 32'd0);
      chk("mid_rst_o_data", o_data, 32'd0);
      chk("mid_rst_o_last", 32'(o_last), 32'd0);
      chk("mid_rst_o_busy", 32'(o_busy), 32'd0);
      chk("mid_rst_o_ready", 32'(o_ready), 32'd1);
      repeat (2) @(posedge i_clk);
      #1;
      i_rst_n = 1'b1;
      run_frame(base);
      chk("rst_frame_w0", got_words[base % 256], 32'h00010203);
      chk("rst_frame_w12", got_words[(base + 12) % 256], 32'h30310000);

      chk("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule
